simple_axi_wr_slave_mem: RTL and testbench
==========================================

// Module: simple_axi_wr_slave_mem
// PURPOSE
//  AXI4 write-channel slave terminating the AW/W/B channels of simple_axi_if in the testbench/DUT fabric.
//  Stores INCR bursts of fixed 4-byte beats into an internal word memory and returns a B response.
//  Provides a sideband synchronous read port so checkers can inspect memory without an AXI read path.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  32    byte address width, matches simple_axi_if
//  C_AXI_DATA_WIDTH  32    data width; fixed 32 (4-byte beats), other values unsupported
//  MEM_DEPTH         1024  number of 32-bit words; valid byte range 0 .. 4*MEM_DEPTH-1
// PORTS
//  aclk          in   1                    clock, all logic rising-edge
//  arstn         in   1                    reset, synchronous, active-low
//  axi_awaddr    in   C_AXI_ADDR_WIDTH     burst start byte address; bits [1:0] ignored
//  axi_awlen     in   8                    beats-1
//  axi_awvalid   in   1                    AW valid
//  axi_awready   out  1                    AW ready
//  axi_wdata     in   32                   write data
//  axi_wstrb     in   4                    byte strobes
//  axi_wlast     in   1                    last beat marker from master
//  axi_wvalid    in   1                    W valid
//  axi_wready    out  1                    W ready
//  axi_bresp     out  2                    write response
//  axi_bvalid    out  1                    B valid
//  axi_bready    in   1                    B ready
//  rd_addr       in   $clog2(MEM_DEPTH)    sideband word index
//  rd_data       out  32                   sideband data, 1-cycle latency
// BEHAVIOUR
//  One clock (aclk); reset synchronous active-low (arstn). awsize=4B and burst=INCR are implied, never checked.
//  Reset (arstn=0 at edge): state=IDLE; awready=0, wready=0, bvalid=0, bresp=2'b00, rd_data=0. Memory not reset.
//  All handshake outputs are registered; awready goes 1 on the first edge after arstn deasserts.
//  FSM IDLE -> DATA -> RESP -> IDLE; one outstanding burst, no AW/W overlap.
//   IDLE: awready=1. On awvalid&&awready: latch idx=awaddr[A-1:2], len=awlen; beat=0; err flags clear; -> DATA.
//     Next-cycle awready=0, wready=1 (1 cycle AW->W ready latency).
//   DATA: wready=1. Per beat (wvalid&&wready):
//     if idx<MEM_DEPTH, write bytes with wstrb[i]=1 to mem[idx]; else drop beat, set dec_err.
//     if wlast != (beat==len), set slv_err.
//     idx++, beat++. Burst ends on beat==len regardless of wlast; -> RESP, wready=0 next cycle.
//     W beats with wvalid=0 simply stall; no timeout.
//   RESP: bvalid=1, bresp = dec_err ? 2'b11 : slv_err ? 2'b10 : 2'b00. bvalid, bresp held stable until bready.
//     On bvalid&&bready -> IDLE, bvalid=0 and awready=1 next cycle.
//  idx is held one bit wider than A-2 bits so bursts never wrap to address 0; overrun beats get DECERR.
//  A burst partially out of range writes the in-range beats and reports DECERR; DECERR overrides SLVERR.
//  Sideband read: rd_data <= mem[rd_addr] every cycle (rd_addr<MEM_DEPTH by width).
//    If the same word is written and read in the same cycle, rd_data returns the old data.
//  Reset mid-burst or mid-RESP: burst is abandoned with no B; words already written are kept.
// STRUCTURE
//  simple_axi_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit constants, BURST_INCR, SIZE_4B, wr_state_e enum.
//  Sub-module simple_axi_wr_mem_array: MEM_DEPTH x 32 RAM, 4-byte write enables, 1 sync read port.
//  Top holds FSM, idx/beat counters, error flags; the target is 120-250 lines of RTL.
// TESTING
//  Single beat: AW addr=0x10 len=0, W 0xDEADBEEF strb=F last=1 -> mem[4]=0xDEADBEEF, bresp=00.
//  INCR 4: addr=0x100 len=3, data 1..4, wvalid gaps -> mem[64..67]=1..4, one B with OKAY.
//  Strobes: preload 0xFFFFFFFF at 0x0, write 0x12345678 strb=0101 -> rd_data=0xFF34FF78.
//  Range: MEM_DEPTH=1024, addr=0xFF8 len=3 -> mem[1022],[1023] written, remaining 2 beats dropped, bresp=11.
//  wlast errors: len=3, wlast on beat1 -> 4 beats accepted, bresp=10. len=1, no wlast -> bresp=10.
//  bready held 0 for 5 cycles -> bvalid, bresp stable, awready=0. Reset in DATA after beat 2 -> awready=0, wready=0,
//    bvalid=0 during reset. The next burst completes with OKAY.

Source files
------------

// File: rtl/simple_axi_pkg.sv
// Shared AXI write-slave constants, response encodings and FSM state type.
// Combinational helper only; no storage.
package simple_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    // A decode error outranks a protocol (wlast) error.
    function automatic logic [1:0] resp_code(input logic dec_err, input logic slv_err);
        if (dec_err)      return RESP_DECERR;
        else if (slv_err) return RESP_SLVERR;
        else              return RESP_OKAY;
    endfunction

endpackage

// File: rtl/simple_axi_wr_mem_array.sv
// Word RAM with per-byte write enables and one synchronous read port.
// Read latency 1 cycle, read-before-write on a same-word collision; never stalls.
module simple_axi_wr_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Storage is deliberately left out of reset so contents survive an abort.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_rdata <= '0;
        else          r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/simple_axi_wr_slave_mem.sv
// AXI4 write slave (AW/W/B) storing INCR bursts of 4-byte beats into a word RAM.
// One burst in flight; AW->W ready 1 cycle, B one cycle after last beat, held until bready.
module simple_axi_wr_slave_mem
    import simple_axi_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH        = 1024
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]                    axi_awlen,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wlast,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [$clog2(MEM_DEPTH)-1:0]  rd_addr,
    output logic [31:0]                   rd_data
);

    // One extra index bit keeps a burst running past the top from wrapping to 0.
    localparam int IDX_W = C_AXI_ADDR_WIDTH - 1;
    localparam int RD_W  = $clog2(MEM_DEPTH);

    wr_state_e        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_len;
    logic [7:0]       r_beat;
    logic             r_dec_err;
    logic             r_slv_err;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    logic             w_beat_fire;
    logic             w_in_range;
    logic             w_last_beat;
    logic             w_dec_nxt;
    logic             w_slv_nxt;
    logic [3:0]       w_mem_we;
    logic             w_unused_ok;

    assign w_beat_fire = (r_state == WR_DATA) && r_wready && axi_wvalid;
    assign w_in_range  = r_idx < IDX_W'(MEM_DEPTH);
    assign w_last_beat = (r_beat == r_len);
    assign w_dec_nxt   = r_dec_err | ~w_in_range;
    assign w_slv_nxt   = r_slv_err | (axi_wlast != w_last_beat);
    assign w_mem_we    = (w_beat_fire && w_in_range) ? axi_wstrb[3:0] : 4'b0000;
    assign w_unused_ok = ^axi_awaddr[1:0];

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_state   <= WR_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_dec_err <= 1'b0;
            r_slv_err <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                WR_IDLE: begin
                    if (r_awready && axi_awvalid) begin
                        r_idx     <= {1'b0, axi_awaddr[C_AXI_ADDR_WIDTH-1:2]};
                        r_len     <= axi_awlen;
                        r_beat    <= '0;
                        r_dec_err <= 1'b0;
                        r_slv_err <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= WR_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_beat_fire) begin
                        r_idx     <= r_idx + 1'b1;
                        r_beat    <= r_beat + 1'b1;
                        r_dec_err <= w_dec_nxt;
                        r_slv_err <= w_slv_nxt;
                        // Burst length comes from awlen; wlast only feeds the error flag.
                        if (w_last_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= resp_code(w_dec_nxt, w_slv_nxt);
                            r_state  <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= WR_IDLE;
                    end
                end
                default: begin
                    r_state   <= WR_IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    simple_axi_wr_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (RD_W)
    ) u_mem (
        .i_clk   (aclk),
        .i_rst_n (arstn),
        .i_we    (w_mem_we),
        .i_waddr (r_idx[RD_W-1:0]),
        .i_wdata (axi_wdata[31:0]),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;

endmodule

// File: tb/tb_simple_axi_wr_slave_mem.sv
// Random and directed bursts against a word-array reference model; a negedge
// monitor scoreboards B responses and sideband reads from expectation queues.
module tb_simple_axi_wr_slave_mem;

    localparam int DEPTH = 1024;
    localparam int TMO   = 60;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic [31:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [31:0] rd_data;

    simple_axi_wr_slave_mem #(
        .C_AXI_ADDR_WIDTH (32),
        .C_AXI_DATA_WIDTH (32),
        .MEM_DEPTH        (DEPTH)
    ) dut (
        .aclk        (aclk),
        .arstn       (arstn),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 aclk = ~aclk;

    // Reference model: memory image plus a record of which words hold defined data.
    logic [31:0] model_mem [DEPTH];
    bit          model_wr  [DEPTH];

    logic [1:0]  exp_b_q [$];
    logic [31:0] exp_rd_q [$];
    int          n_cmp = 0;
    int          n_mis = 0;
    bit          rd_pend = 1'b0;
    bit          rd_armed = 1'b0;

    // Per-beat stimulus for the next burst.
    logic [31:0] bd [256];
    logic [3:0]  bs [256];
    bit          bl [256];
    int          bg [256];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: B channel and sideband reads, compared away from the rising edge.
    always @(negedge aclk) begin
        if (rd_armed && exp_rd_q.size() > 0) check("rd_data", rd_data, exp_rd_q.pop_front());
        rd_armed = rd_pend;
        if (arstn && axi_bvalid) begin
            if (exp_b_q.size() == 0) begin
                check("bvalid_unexpected", {31'd0, axi_bvalid}, 32'd0);
            end else begin
                check("bresp", {30'd0, axi_bresp}, {30'd0, exp_b_q[0]});
                check("awready_in_resp", {31'd0, axi_awready}, 32'd0);
                if (axi_bready) void'(exp_b_q.pop_front());
            end
        end
    end

    task automatic set_beat(input int b, input logic [31:0] d, input logic [3:0] s,
                            input bit l, input int g);
        bd[b] = d; bs[b] = s; bl[b] = l; bg[b] = g;
    endtask

    // abort_at >= 0: assert reset just before that beat; beats before it are kept.
    task automatic do_burst(input logic [31:0] addr, input int len, input int bdelay,
                            input int abort_at);
        int  idx;
        int  to;
        bit  dec;
        bit  slv;
        idx = int'(addr >> 2);
        dec = 0;
        slv = 0;
        for (int b = 0; b <= len; b++) begin
            if (abort_at >= 0 && b >= abort_at) break;
            if (idx + b < DEPTH) begin
                for (int k = 0; k < 4; k++)
                    if (bs[b][k]) model_mem[idx + b][8*k +: 8] = bd[b][8*k +: 8];
                model_wr[idx + b] = 1'b1;
            end else begin
                dec = 1;
            end
            if (bl[b] != (b == len)) slv = 1;
        end
        if (abort_at < 0) exp_b_q.push_back(dec ? 2'b11 : slv ? 2'b10 : 2'b00);

        @(posedge aclk); #1;
        axi_awaddr = addr; axi_awlen = 8'(len); axi_awvalid = 1'b1;
        to = 0;
        do begin @(negedge aclk); to++; end while (!axi_awready && to < TMO);
        if (!axi_awready) check("awready_timeout", {31'd0, axi_awready}, 32'd1);
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;

        for (int b = 0; b <= len; b++) begin
            if (b == abort_at) begin
                arstn = 1'b0;
                repeat (2) @(posedge aclk);
                @(negedge aclk);
                check("rst_awready", {31'd0, axi_awready}, 32'd0);
                check("rst_wready",  {31'd0, axi_wready},  32'd0);
                check("rst_bvalid",  {31'd0, axi_bvalid},  32'd0);
                check("rst_rd_data", rd_data, 32'd0);
                @(posedge aclk); #1;
                arstn = 1'b1;
                @(posedge aclk);
                @(negedge aclk);
                check("awready_after_rst", {31'd0, axi_awready}, 32'd1);
                return;
            end
            repeat (bg[b]) @(posedge aclk);
            #1;
            axi_wdata = bd[b]; axi_wstrb = bs[b]; axi_wlast = bl[b]; axi_wvalid = 1'b1;
            to = 0;
            do begin @(negedge aclk); to++; end while (!axi_wready && to < TMO);
            if (!axi_wready) check("wready_timeout", {31'd0, axi_wready}, 32'd1);
            @(posedge aclk); #1;
            axi_wvalid = 1'b0; axi_wlast = 1'b0;
        end

        to = 0;
        do begin @(negedge aclk); to++; end while (!axi_bvalid && to < TMO);
        if (!axi_bvalid) begin
            check("bvalid_timeout", {31'd0, axi_bvalid}, 32'd1);
            if (exp_b_q.size() > 0) void'(exp_b_q.pop_front());
            return;
        end
        repeat (bdelay) @(posedge aclk);
        @(posedge aclk); #1;
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic read_word(input int idx);
        @(posedge aclk); #1;
        rd_addr = 10'(idx);
        exp_rd_q.push_back(model_mem[idx]);
        rd_pend = 1'b1;
        @(posedge aclk); #1;
        rd_pend = 1'b0;
    endtask

    task automatic read_back(input logic [31:0] addr, input int len);
        for (int b = 0; b <= len; b++) begin
            int w;
            w = int'(addr >> 2) + b;
            if (w < DEPTH && model_wr[w]) read_word(w);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_wr[i] = 1'b0; end

        // Reset state.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_awready", {31'd0, axi_awready}, 32'd0);
        check("reset_wready",  {31'd0, axi_wready},  32'd0);
        check("reset_bvalid",  {31'd0, axi_bvalid},  32'd0);
        check("reset_bresp",   {30'd0, axi_bresp},   32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        @(posedge aclk); #1;
        arstn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("awready_first_edge", {31'd0, axi_awready}, 32'd1);

        // Single beat.
        set_beat(0, 32'hDEADBEEF, 4'hF, 1, 0);
        do_burst(32'h10, 0, 0, -1);
        read_back(32'h10, 0);

        // INCR 4 with wvalid gaps.
        for (int b = 0; b < 4; b++) set_beat(b, 32'(b + 1), 4'hF, b == 3, b % 2 + 1);
        do_burst(32'h100, 3, 1, -1);
        read_back(32'h100, 3);

        // Partial strobes over a preloaded word.
        set_beat(0, 32'hFFFFFFFF, 4'hF, 1, 0);
        do_burst(32'h0, 0, 0, -1);
        set_beat(0, 32'h12345678, 4'b0101, 1, 0);
        do_burst(32'h0, 0, 0, -1);
        read_back(32'h0, 0);

        // Burst running off the top of memory.
        for (int b = 0; b < 4; b++) set_beat(b, 32'hA0 + 32'(b), 4'hF, b == 3, 0);
        do_burst(32'hFF8, 3, 0, -1);
        read_back(32'hFF8, 1);

        // wlast too early, and missing.
        for (int b = 0; b < 4; b++) set_beat(b, 32'hB0 + 32'(b), 4'hF, b == 1, 0);
        do_burst(32'h200, 3, 0, -1);
        read_back(32'h200, 3);
        for (int b = 0; b < 2; b++) set_beat(b, 32'hC0 + 32'(b), 4'hF, 0, 0);
        do_burst(32'h300, 1, 0, -1);

        // Long bready stall.
        set_beat(0, 32'h5555AAAA, 4'hF, 1, 0);
        do_burst(32'h40, 0, 5, -1);

        // Reset in DATA after two beats, then a clean burst.
        for (int b = 0; b < 4; b++) set_beat(b, 32'hD0 + 32'(b), 4'hF, b == 3, 0);
        do_burst(32'h400, 3, 0, 2);
        read_back(32'h400, 1);
        for (int b = 0; b < 2; b++) set_beat(b, 32'hE0 + 32'(b), 4'hF, b == 1, 0);
        do_burst(32'h500, 1, 0, -1);
        read_back(32'h500, 1);

        // Randomized bursts.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int          len;
            a   = 32'($urandom_range(0, 32'h1080));
            len = $urandom_range(0, 7);
            for (int b = 0; b <= len; b++) begin
                bit l;
                l = (b == len);
                if ($urandom_range(0, 9) == 0) l = ~l;
                set_beat(b, $urandom, 4'($urandom_range(0, 15)), l, $urandom_range(0, 2));
            end
            do_burst(a, len, $urandom_range(0, 3), -1);
            read_back(a, len);
        end

        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
